// File: rtl/contador_lector.sv
// contador_lector: sweeps counters 0..4 through a request/valid handshake and
// captures each returned count plus a running total. An index that does not
// answer within TIMEOUT cycles is recorded as zero and flagged in error.
module contador_lector #(
  parameter int TIMEOUT = 4,
  parameter int DATA_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  input  logic              valid,
  output logic              req,
  output logic [2:0]        idx,
  output logic [DATA_W-1:0] count0,
  output logic [DATA_W-1:0] count1,
  output logic [DATA_W-1:0] count2,
  output logic [DATA_W-1:0] count3,
  output logic [DATA_W-1:0] count4,
  output logic [8:0]        total,
  output logic              busy,
  output logic              done,
  output logic              error
);

  // The timeout counter must be able to hold the value TIMEOUT itself.
  localparam int              TW        = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]   TIMEOUT_V = TW'(TIMEOUT);
  localparam logic [2:0]      LAST_IDX  = 3'd4;
  localparam int              N_CNT     = 5;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_t;

  state_t            state;
  logic [TW-1:0]     tcnt;
  logic [DATA_W-1:0] counts [N_CNT];

  // Sweep sequencer: one single-cycle request per index, then wait for valid
  // or give up once the timeout counter has reached TIMEOUT.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values, exactly like the flops it describes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      req   <= 1'b0;
      idx   <= 3'd0;
      total <= 9'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
      error <= 1'b0;
      tcnt  <= '0;
      // NOTE: the capture registers are visible outputs that must read zero
      // straight out of reset, so this small array is reset like any other
      // register instead of being left as uninitialised storage.
      for (int i = 0; i < N_CNT; i++) counts[i] <= '0;
    end else begin
      // done is a single-cycle pulse unless the advance below re-asserts it.
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            req   <= 1'b1;
            idx   <= 3'd0;
            total <= 9'd0;
            error <= 1'b0;
            for (int i = 0; i < N_CNT; i++) counts[i] <= '0;
            state <= REQ;
          end
        end

        REQ: begin
          // The request is only ever one cycle wide, so each request draws
          // exactly one valid pulse from the counter block.
          req   <= 1'b0;
          tcnt  <= '0;
          state <= WAIT;
        end

        WAIT: begin
          if (valid || (tcnt == TIMEOUT_V)) begin
            if (valid) begin
              for (int i = 0; i < N_CNT; i++) begin
                if (idx == 3'(i)) counts[i] <= data;
              end
              total <= total + 9'(data);
            end else begin
              // Unanswered index: its count stays at the zero set on start.
              error <= 1'b1;
            end
            tcnt <= '0;
            if (idx == LAST_IDX) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              req   <= 1'b0;
              state <= IDLE;
            end else begin
              req   <= 1'b1;
              idx   <= idx + 3'd1;
              state <= REQ;
            end
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Captured counts are exposed as individual ports.
  assign count0 = counts[0];
  assign count1 = counts[1];
  assign count2 = counts[2];
  assign count3 = counts[3];
  assign count4 = counts[4];

endmodule

// File: tb/tb_contador_lector.sv
// Testbench for contador_lector: a responder models the counter block and a
// timeline model predicts every output on every cycle of a sweep.
module tb_contador_lector;

  localparam int TIMEOUT = 4;
  localparam int DATA_W  = 6;

  logic              clk   = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              req;
  logic [2:0]        idx;
  logic [DATA_W-1:0] count0, count1, count2, count3, count4;
  logic [8:0]        total;
  logic              busy, done, error;

  // Responder / stimulus state
  logic              rsp_valid  = 1'b0;
  logic [DATA_W-1:0] rsp_data   = '0;
  logic [DATA_W-1:0] junk       = '0;
  logic              spur_valid = 1'b0;
  logic              rsp_hit;
  logic [2:0]        rsp_i;
  logic [DATA_W-1:0] mem  [5];
  bit                mute [5];
  logic [DATA_W-1:0] cnt_out [5];

  // Results of the last completed sweep, for hold checks
  int last_cnt [5];
  int last_tot;
  bit last_err;

  int cyc         = 0;
  int vectors     = 0;
  int miscompares = 0;

  contador_lector #(.TIMEOUT(TIMEOUT), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .data  (data),
    .valid (valid),
    .req   (req),
    .idx   (idx),
    .count0(count0),
    .count1(count1),
    .count2(count2),
    .count3(count3),
    .count4(count4),
    .total (total),
    .busy  (busy),
    .done  (done),
    .error (error)
  );

  assign valid = rsp_valid | spur_valid;
  assign data  = rsp_valid ? rsp_data : (spur_valid ? DATA_W'(9) : junk);
  assign cnt_out[0] = count0;
  assign cnt_out[1] = count1;
  assign cnt_out[2] = count2;
  assign cnt_out[3] = count3;
  assign cnt_out[4] = count4;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Counter block model: answers a sampled request one cycle later unless
  // that index is muted; data carries junk whenever valid is low.
  always @(posedge clk) begin
    rsp_hit = req;
    rsp_i   = idx;
    #1;
    rsp_valid = rsp_hit && (rsp_i < 3'd5) && !mute[rsp_i];
    rsp_data  = (rsp_hit && rsp_i < 3'd5) ? mem[rsp_i] : '0;
    junk      = DATA_W'($urandom);
  end

  // One sweep checked cycle by cycle against a timeline derived from the
  // handshake rules: 2 cycles per answered index, 2+TIMEOUT per muted one.
  task automatic run_sweep(input bit mid_start, input bit chain_out,
                           input bit chained_in, input bit spur_in_req);
    int k, done_e, last, t, exp_tot;
    int req_e [5];
    int cap_e [5];
    int exp_cnt [5];
    bit exp_req, exp_busy, exp_done, exp_err;
    logic [2:0] exp_idx;
    if (!chained_in) begin
      @(negedge clk);
      start = 1'b1;
    end
    k = cyc + 1;
    @(negedge clk);
    t = k;
    for (int i = 0; i < 5; i++) begin
      req_e[i] = t;
      cap_e[i] = t + 2 + (mute[i] ? TIMEOUT : 0);
      t = cap_e[i];
    end
    done_e = t;
    last   = chain_out ? done_e : done_e + 2;
    for (int c = k; c <= last; c++) begin
      if (c != k) @(negedge clk);
      start      = (mid_start && c == k + 3) || (chain_out && c == done_e);
      spur_valid = spur_in_req && (c == req_e[2]);
      exp_req = 1'b0; exp_idx = 3'd0; exp_err = 1'b0; exp_tot = 0;
      for (int i = 0; i < 5; i++) begin
        if (req_e[i] == c) exp_req = 1'b1;
        if (req_e[i] <= c) exp_idx = 3'(i);
        exp_cnt[i] = 0;
        if (cap_e[i] <= c) begin
          if (mute[i]) exp_err = 1'b1;
          else begin
            exp_cnt[i] = int'(mem[i]);
            exp_tot += int'(mem[i]);
          end
        end
      end
      exp_busy = (c < done_e);
      exp_done = (c == done_e);
      vectors++;
      if (req !== exp_req) begin
        miscompares++;
        $display("FAIL req cyc=%0d got=%0b exp=%0b", c - k, req, exp_req);
      end
      vectors++;
      if (idx !== exp_idx) begin
        miscompares++;
        $display("FAIL idx cyc=%0d got=%0d exp=%0d", c - k, idx, exp_idx);
      end
      vectors++;
      if (busy !== exp_busy) begin
        miscompares++;
        $display("FAIL busy cyc=%0d got=%0b exp=%0b", c - k, busy, exp_busy);
      end
      vectors++;
      if (done !== exp_done) begin
        miscompares++;
        $display("FAIL done cyc=%0d got=%0b exp=%0b", c - k, done, exp_done);
      end
      vectors++;
      if (error !== exp_err) begin
        miscompares++;
        $display("FAIL error cyc=%0d got=%0b exp=%0b", c - k, error, exp_err);
      end
      vectors++;
      if (total !== 9'(exp_tot)) begin
        miscompares++;
        $display("FAIL total cyc=%0d got=%0d exp=%0d", c - k, total, exp_tot);
      end
      for (int i = 0; i < 5; i++) begin
        vectors++;
        if (cnt_out[i] !== DATA_W'(exp_cnt[i])) begin
          miscompares++;
          $display("FAIL count%0d cyc=%0d got=%0d exp=%0d", i, c - k, cnt_out[i], exp_cnt[i]);
        end
      end
      for (int i = 0; i < 5; i++) last_cnt[i] = exp_cnt[i];
      last_tot = exp_tot;
      last_err = exp_err;
    end
    spur_valid = 1'b0;
    if (!chain_out) start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    vectors++;
    if ({req, idx, busy, done, error} !== 7'd0 || total !== 9'd0) begin
      miscompares++;
      $display("FAIL %s ctrl got=req%0b idx%0d busy%0b done%0b err%0b tot%0d exp=all 0",
               tag, req, idx, busy, done, error, total);
    end
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (cnt_out[i] !== '0) begin
        miscompares++;
        $display("FAIL %s count%0d got=%0d exp=0", tag, i, cnt_out[i]);
      end
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #2 check_all_zero("reset_async");
    repeat (2) @(negedge clk);
    check_all_zero("reset_held");
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset_release");
  endtask

  task automatic test_directed();
    mem[0] = 6'd3; mem[1] = 6'd0; mem[2] = 6'd7; mem[3] = 6'd15; mem[4] = 6'd1;
    for (int i = 0; i < 5; i++) mute[i] = 1'b0;
    run_sweep(1'b0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (last_tot != 26) begin
      miscompares++;
      $display("FAIL directed_model_total got=%0d exp=26", last_tot);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 5; i++) begin mem[i] = 6'd63; mute[i] = 1'b0; end
    run_sweep(1'b0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (total !== 9'd315) begin
      miscompares++;
      $display("FAIL saturate_total got=%0d exp=315", total);
    end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 5; i++) begin
      mem[i]  = DATA_W'($urandom_range(1, 63));
      mute[i] = (i == 2);
    end
    run_sweep(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) mute[i] = 1'b0;
  endtask

  task automatic test_spurious_idle();
    @(negedge clk);
    spur_valid = 1'b1;
    @(negedge clk);
    spur_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (total !== 9'(last_tot) || busy !== 1'b0 || req !== 1'b0 || error !== last_err) begin
        miscompares++;
        $display("FAIL spurious_idle got=tot%0d busy%0b req%0b err%0b exp=tot%0d busy0 req0 err%0b",
                 total, busy, req, error, last_tot, last_err);
      end
      for (int i = 0; i < 5; i++) begin
        vectors++;
        if (cnt_out[i] !== DATA_W'(last_cnt[i])) begin
          miscompares++;
          $display("FAIL spurious_idle count%0d got=%0d exp=%0d", i, cnt_out[i], last_cnt[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) begin mem[i] = DATA_W'($urandom); mute[i] = 1'b0; end
    run_sweep(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) mem[i] = DATA_W'($urandom);
    run_sweep(1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin mem[i] = DATA_W'($urandom_range(1, 63)); mute[i] = 1'b0; end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    vectors++;
    if (req !== 1'b1 || idx !== 3'd3) begin
      miscompares++;
      $display("FAIL reset_mid_pre got=req%0b idx%0d exp=req1 idx3", req, idx);
    end
    #2 reset = 1'b1;
    #1 check_all_zero("reset_mid");
    @(negedge clk);
    reset = 1'b0;
    repeat (15) begin
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0 || req !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_mid_after got=done%0b busy%0b req%0b exp=0 0 0", done, busy, req);
      end
    end
    run_sweep(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    bit chain = 1'b0;
    bit nxt;
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < 5; i++) begin
        mem[i]  = DATA_W'($urandom);
        mute[i] = ($urandom_range(0, 3) == 0);
      end
      nxt = (n != 19) && ($urandom_range(0, 2) == 0);
      run_sweep(1'($urandom_range(0, 1)), nxt, chain, 1'($urandom_range(0, 1)));
      chain = nxt;
    end
    for (int i = 0; i < 5; i++) mute[i] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 5; i++) begin mem[i] = '0; mute[i] = 1'b0; end
    test_reset();
    test_directed();
    test_spurious_idle();
    test_saturate();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_spurious_idle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/contador_lector.md
CONTADOR_LECTOR -- requirements
Module: contador_lector

Interface
REQ-001 Parameter TIMEOUT, default 4: cycles to wait for valid after a request before declaring the index unanswered.
REQ-002 Parameter DATA_W, default 6: width of the counter data bus and of each captured count.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  pulse requesting one sweep of counters 0..4.
REQ-006 data  input  DATA_W  count returned by the counter block.
REQ-007 valid  input  1  qualifies data; the counter block asserts it one cycle after sampling req.
REQ-008 req  output  1  registered request to the counter block.
REQ-009 idx  output  3  registered counter index, 0..4, qualified by req.
REQ-010 count0..count4  output  DATA_W each  captured count per index.
REQ-011 total  output  9  sum of count0..count4 for the last sweep; maximum 5*63 = 315, no overflow.
REQ-012 busy  output  1  high while a sweep is in progress.
REQ-013 done  output  1  one-cycle pulse at the end of a sweep.
REQ-014 error  output  1  sticky flag: at least one index timed out in the current/last sweep.

Function
REQ-015 The FSM SHALL have states IDLE, REQ, WAIT; all outputs SHALL be registered.
REQ-016 IDLE: start=1 sampled -> busy<=1, req<=1, idx<=0, count0..4<=0, total<=0, error<=0; next state REQ.
REQ-017 REQ: lasts exactly one cycle; req<=0; timeout counter<=0; next state WAIT.
REQ-018 WAIT, valid=1: count[idx]<=data, total<=total+data (zero-extended to 9 bits), timeout counter cleared.
REQ-019 WAIT, valid=1, idx<4: req<=1, idx<=idx+1; next state REQ (back-to-back; 2 cycles per index).
REQ-020 WAIT, valid=1, idx=4: done<=1, busy<=0, req<=0; next state IDLE.
REQ-021 WAIT, valid=0: timeout counter increments; when it reaches TIMEOUT, count[idx] stays 0, error<=1, then advance exactly as REQ-019/REQ-020.
REQ-022 Latency: start sampled at edge k -> count i captured at edge k+2i+2; done high for the cycle after edge k+10 with no timeouts.
REQ-023 done SHALL deassert on the edge after it is asserted.
REQ-024 start while busy=1 SHALL be ignored; start in the cycle done is high SHALL be accepted (state is IDLE).
REQ-025 valid while in IDLE or REQ SHALL be ignored; no output changes.
REQ-026 req SHALL never be high for two consecutive cycles, so each request yields exactly one valid pulse.
REQ-027 idx SHALL hold its last value when req=0; values 5..7 SHALL never be driven.
REQ-028 count0..4 and total SHALL hold after done until the next accepted start.

Reset
REQ-029 reset=1 SHALL immediately, without waiting for clk, force state IDLE and req, idx, count0..4, total, busy, done, error and the timeout counter to 0.
REQ-030 reset asserted mid-sweep SHALL abandon the sweep; no done pulse is produced; after release the block waits for a new start.

Verification
REQ-031 Counters preloaded to 3,0,7,15,1; single start pulse -> req pulses with idx 0..4 two cycles apart; count0..4=3,0,7,15,1; total=26; done one cycle at edge k+10; error=0.
REQ-032 All counters at 63 (data forced) -> total=315, no wrap.
REQ-033 Responder suppresses valid for idx 2 -> count2=0, error=1, sweep continues to idx 4, done asserted TIMEOUT cycles later than nominal.
REQ-034 Second start pulse during busy -> ignored; exactly one done; start during the done cycle -> new sweep begins, counts and total cleared.
REQ-035 reset asserted between clock edges at idx 3 -> all outputs 0 before the next edge; no done; subsequent start completes a normal sweep.
REQ-036 Spurious valid in IDLE with data=9 -> count0..4 and total unchanged.
